muldiv_seq: RTL



---
 rtl/muldiv_seq_pkg.sv | 22 ++
 rtl/muldiv_seq_step.sv | 36 +++
 rtl/muldiv_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared types for the iterative HI/LO multiply/divide sequencer.
// Opcodes, FSM states and the iteration count used by muldiv_seq.
package muldiv_seq_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_MUL  = 3'd1,
        OP_MADD = 3'd2,
        OP_DIV  = 3'd3,
        OP_MTHI = 3'd4,
        OP_MTLO = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2
    } muldiv_state_t;

    localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/muldiv_seq_step.sv
// One combinational iteration of the shared shift/add-subtract datapath.
// Multiply: shift-add over {acc, opnd}. Divide: restoring step over {rem, quotient}.
module muldiv_seq_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_div_mode,
    input  logic [DATA_WIDTH-1:0] i_acc,
    input  logic [DATA_WIDTH-1:0] i_opnd,
    input  logic [DATA_WIDTH-1:0] i_mcand,
    output logic [DATA_WIDTH-1:0] o_acc,
    output logic [DATA_WIDTH-1:0] o_opnd
);

    logic [DATA_WIDTH-1:0] w_addend;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_rem_lo;
    logic [DATA_WIDTH-1:0] w_diff;
    logic                  w_ge;

    // Datapath for both modes; a set shifted-out remainder MSB always means rem >= divisor.
    always_comb begin
        w_addend = i_opnd[0] ? i_mcand : {DATA_WIDTH{1'b0}};
        w_sum    = {1'b0, i_acc} + {1'b0, w_addend};
        w_rem_lo = {i_acc[DATA_WIDTH-2:0], i_opnd[DATA_WIDTH-1]};
        w_diff   = w_rem_lo - i_mcand;
        w_ge     = i_acc[DATA_WIDTH-1] | (w_rem_lo >= i_mcand);
        if (i_div_mode) begin
            o_acc  = w_ge ? w_diff : w_rem_lo;
            o_opnd = {i_opnd[DATA_WIDTH-2:0], w_ge};
        end else begin
            o_acc  = w_sum[DATA_WIDTH:1];
            o_opnd = {w_sum[0], i_opnd[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO owner executing MULT/MADD/DIV (signed or unsigned) one bit per cycle,
// plus single-cycle MTHI/MTLO, behind a valid/ready handshake with flush.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int DATA_WIDTH = MULDIV_ITERS
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  muldiv_op_t            req_op,
    input  logic                  req_u,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic                  flush,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  done
);

    localparam int CW = $clog2(DATA_WIDTH);

    function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] v,
                                                      input logic neg);
        return neg ? (-v) : v;
    endfunction

    muldiv_state_t           r_state;
    muldiv_op_t              r_op;
    logic [CW-1:0]           r_count;
    logic                    r_neg_prod;
    logic                    r_neg_quot;
    logic                    r_neg_rem;
    logic                    r_div_zero;
    logic [DATA_WIDTH-1:0]   r_orig_a;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]   r_opnd;
    logic [DATA_WIDTH-1:0]   r_mcand;
    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_lo;
    logic                    r_done;

    logic [DATA_WIDTH-1:0]   w_next_acc;
    logic [DATA_WIDTH-1:0]   w_next_opnd;
    logic                    w_a_neg;
    logic                    w_b_neg;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [2*DATA_WIDTH-1:0] w_commit;

    muldiv_seq_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .i_div_mode (r_op == OP_DIV),
        .i_acc      (r_acc),
        .i_opnd     (r_opnd),
        .i_mcand    (r_mcand),
        .o_acc      (w_next_acc),
        .o_opnd     (w_next_opnd)
    );

    // Operand sign detection at accept time; unsigned variants never negate.
    always_comb begin
        w_a_neg = ~req_u & req_a[DATA_WIDTH-1];
        w_b_neg = ~req_u & req_b[DATA_WIDTH-1];
    end

    // Sign fixup and the value committed to {HI,LO} on the FIXUP edge.
    always_comb begin
        w_prod = r_neg_prod ? (-{r_acc, r_opnd}) : {r_acc, r_opnd};
        case (r_op)
            OP_MUL:  w_commit = w_prod;
            OP_MADD: w_commit = {r_hi, r_lo} + w_prod;
            OP_DIV: begin
                if (r_div_zero) begin
                    w_commit = {r_orig_a, {DATA_WIDTH{1'b1}}};
                end else begin
                    w_commit = {abs_val(r_acc, r_neg_rem), abs_val(r_opnd, r_neg_quot)};
                end
            end
            default: w_commit = {r_hi, r_lo};
        endcase
    end

    // Sequencer FSM, iteration registers and committed HI/LO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_NONE;
            r_count    <= {CW{1'b0}};
            r_neg_prod <= 1'b0;
            r_neg_quot <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_orig_a   <= {DATA_WIDTH{1'b0}};
            r_acc      <= {DATA_WIDTH{1'b0}};
            r_opnd     <= {DATA_WIDTH{1'b0}};
            r_mcand    <= {DATA_WIDTH{1'b0}};
            r_hi       <= {DATA_WIDTH{1'b0}};
            r_lo       <= {DATA_WIDTH{1'b0}};
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && !flush) begin
                        case (req_op)
                            OP_MTHI: r_hi <= req_a;
                            OP_MTLO: r_lo <= req_a;
                            OP_MUL, OP_MADD, OP_DIV: begin
                                r_state    <= ST_RUN;
                                r_op       <= req_op;
                                r_count    <= CW'(DATA_WIDTH - 1);
                                r_neg_prod <= w_a_neg ^ w_b_neg;
                                r_neg_quot <= w_a_neg ^ w_b_neg;
                                r_neg_rem  <= w_a_neg;
                                r_div_zero <= (req_b == {DATA_WIDTH{1'b0}});
                                r_orig_a   <= req_a;
                                r_acc      <= {DATA_WIDTH{1'b0}};
                                r_opnd     <= abs_val(req_a, w_a_neg);
                                r_mcand    <= abs_val(req_b, w_b_neg);
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc   <= w_next_acc;
                        r_opnd  <= w_next_opnd;
                        r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
                        if (r_count == {CW{1'b0}}) begin
                            r_state <= ST_FIXUP;
                        end
                    end
                end
                ST_FIXUP: begin
                    r_state <= ST_IDLE;
                    if (!flush) begin
                        {r_hi, r_lo} <= w_commit;
                        r_done       <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign done      = r_done;

endmodule
